// File: rtl/id_ex_stage.sv
// id_ex_stage: RV32I decode stage.
// Holds the IF/ID register and the ID/EX pipeline register, drives the
// register-file read addresses, generates the immediate, inserts one bubble
// per load-use hazard and honours a flush from EX.
// Optional build macro ID_STALL_CNT_EN adds saturating stall/flush counters
// (ports stall_cnt, flush_cnt).
module id_ex_stage #(
  parameter int unsigned XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            id_ready,
  output logic [4:0]      rf_a1,
  output logic [4:0]      rf_a2,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  input  logic            flush_i,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_reg_write
`ifdef ID_STALL_CNT_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
`endif
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
  } ex_t;

  logic            id_valid;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc;

  logic [6:0]      opcode;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic            use_rs1;
  logic            use_rs2;
  logic            writes_rd;
  logic            mem_read_c;
  logic            mem_write_c;
  logic [XLEN-1:0] imm_c;
  logic            hz;

  ex_t ex_q;
  ex_t ex_d;

  assign opcode = id_instr[6:0];
  assign rd     = id_instr[11:7];
  assign rs1    = id_instr[19:15];
  assign rs2    = id_instr[24:20];
  assign rf_a1  = rs1;
  assign rf_a2  = rs2;

  // Opcode decode: source usage, control bits and immediate format.
  always_comb begin
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    writes_rd   = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    imm_c       = '0;
    case (opcode)
      OPC_OP: begin
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_OP_IMM, OPC_JALR: begin
        use_rs1   = 1'b1;
        writes_rd = 1'b1;
        imm_c     = {{20{id_instr[31]}}, id_instr[31:20]};
      end
      OPC_LOAD: begin
        use_rs1    = 1'b1;
        writes_rd  = 1'b1;
        mem_read_c = 1'b1;
        imm_c      = {{20{id_instr[31]}}, id_instr[31:20]};
      end
      OPC_STORE: begin
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
        mem_write_c = 1'b1;
        imm_c       = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm_c   = {{19{id_instr[31]}}, id_instr[31], id_instr[7],
                   id_instr[30:25], id_instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        writes_rd = 1'b1;
        imm_c     = {id_instr[31:12], 12'h000};
      end
      OPC_JAL: begin
        writes_rd = 1'b1;
        imm_c     = {{11{id_instr[31]}}, id_instr[31], id_instr[19:12],
                     id_instr[20], id_instr[30:21], 1'b0};
      end
      default: begin
        // Unknown opcodes travel as valid instructions with no side effect.
      end
    endcase
  end

  // Load-use hazard against the load currently sitting in ID/EX.
  assign hz = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) &
              ((use_rs1 & (ex_q.rd == rs1)) | (use_rs2 & (ex_q.rd == rs2)));

  assign id_ready = ~hz | flush_i;

  // Next ID/EX contents: decoded instruction, or an all-zero bubble.
  always_comb begin
    ex_d = '0;
    if (id_valid && !hz && !flush_i) begin
      ex_d.valid     = 1'b1;
      ex_d.pc        = id_pc;
      ex_d.rs1_data  = rf_rd1;
      ex_d.rs2_data  = rf_rd2;
      ex_d.imm       = imm_c;
      ex_d.rs1       = use_rs1 ? rs1 : 5'd0;
      ex_d.rs2       = use_rs2 ? rs2 : 5'd0;
      ex_d.rd        = rd;
      ex_d.opcode    = opcode;
      ex_d.funct3    = id_instr[14:12];
      ex_d.funct7b5  = id_instr[30];
      ex_d.mem_read  = mem_read_c;
      ex_d.mem_write = mem_write_c;
      ex_d.reg_write = writes_rd & (rd != 5'd0);
    end
  end

  // IF/ID register: flush kills, hazard holds, otherwise accept fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
      id_pc    <= '0;
    end else if (flush_i) begin
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
      id_pc    <= '0;
    end else if (!hz) begin
      id_valid <= if_valid;
      id_instr <= if_instr;
      id_pc    <= if_pc;
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_pc        = ex_q.pc;
  assign ex_rs1_data  = ex_q.rs1_data;
  assign ex_rs2_data  = ex_q.rs2_data;
  assign ex_imm       = ex_q.imm;
  assign ex_rs1       = ex_q.rs1;
  assign ex_rs2       = ex_q.rs2;
  assign ex_rd        = ex_q.rd;
  assign ex_opcode    = ex_q.opcode;
  assign ex_funct3    = ex_q.funct3;
  assign ex_funct7b5  = ex_q.funct7b5;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_mem_write = ex_q.mem_write;
  assign ex_reg_write = ex_q.reg_write;

`ifdef ID_STALL_CNT_EN
  // Saturating counters of stall and flush edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hz && !flush_i && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (flush_i && (flush_cnt != 32'hFFFF_FFFF)) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`else
  // Event counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes expected EX entries
// (tagged with the clock edge they must appear on), a monitor pops them.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic [4:0]  rf_a1;
  logic [4:0]  rf_a2;
  logic [31:0] rf_rd1;
  logic [31:0] rf_rd2;
  logic        flush_i;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs1_data;
  logic [31:0] ex_rs2_data;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_reg_write;
`ifdef ID_STALL_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  id_ex_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .id_ready     (id_ready),
    .rf_a1        (rf_a1),
    .rf_a2        (rf_a2),
    .rf_rd1       (rf_rd1),
    .rf_rd2       (rf_rd2),
    .flush_i      (flush_i),
    .ex_valid     (ex_valid),
    .ex_pc        (ex_pc),
    .ex_rs1_data  (ex_rs1_data),
    .ex_rs2_data  (ex_rs2_data),
    .ex_imm       (ex_imm),
    .ex_rs1       (ex_rs1),
    .ex_rs2       (ex_rs2),
    .ex_rd        (ex_rd),
    .ex_opcode    (ex_opcode),
    .ex_funct3    (ex_funct3),
    .ex_funct7b5  (ex_funct7b5),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_reg_write (ex_reg_write)
`ifdef ID_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  typedef struct {
    int          edge_n;
    logic [31:0] pc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7;
    logic        mr;
    logic        mw;
    logic        rw;
  } exp_t;

  exp_t q[$];
  int   n_chk;
  int   n_fail;
  int   edge_cnt;

  // Register-file model: each register holds a recognisable constant.
  function automatic logic [31:0] rf_val(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : (32'hA5A5_0000 | 32'(a));
  endfunction

  assign rf_rd1 = rf_val(rf_a1);
  assign rf_rd2 = rf_val(rf_a2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic push_exp(input int e, input logic [31:0] pc, input logic [31:0] ins,
                          input logic [31:0] imm, input bit u1, input bit u2,
                          input bit mr, input bit mw, input bit rw);
    exp_t x;
    x.edge_n = e;
    x.pc     = pc;
    x.rs1d   = rf_val(ins[19:15]);
    x.rs2d   = rf_val(ins[24:20]);
    x.imm    = imm;
    x.rs1    = u1 ? ins[19:15] : 5'd0;
    x.rs2    = u2 ? ins[24:20] : 5'd0;
    x.rd     = ins[11:7];
    x.opc    = ins[6:0];
    x.f3     = ins[14:12];
    x.f7     = ins[30];
    x.mr     = mr;
    x.mw     = mw;
    x.rw     = rw;
    q.push_back(x);
  endtask

  // Drive one fetch cycle at the falling edge and check id_ready.
  task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit fl, input bit exp_rdy, output int e);
    @(negedge clk);
    e        = edge_cnt;
    if_valid = v;
    if_instr = ins;
    if_pc    = pc;
    flush_i  = fl;
    #1;
    chk("id_ready", 160'(id_ready), 160'(exp_rdy));
  endtask

  function automatic logic [159:0] ex_all();
    return 160'({ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2,
                 ex_rd, ex_opcode, ex_funct3, ex_funct7b5, ex_mem_read,
                 ex_mem_write, ex_reg_write});
  endfunction

  // Monitor: pop and compare whenever EX holds a valid instruction.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (rst_n) begin
      if (ex_valid) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_ex: got pc %h opcode %h expected no instruction (edge %0d)",
                   ex_pc, ex_opcode, edge_cnt);
        end else begin
          x = q.pop_front();
          chk("ex_edge", 160'(edge_cnt), 160'(x.edge_n));
          chk("ex_pc", 160'(ex_pc), 160'(x.pc));
          chk("ex_rs1_data", 160'(ex_rs1_data), 160'(x.rs1d));
          chk("ex_rs2_data", 160'(ex_rs2_data), 160'(x.rs2d));
          chk("ex_imm", 160'(ex_imm), 160'(x.imm));
          chk("ex_rs1_rs2_rd", 160'({ex_rs1, ex_rs2, ex_rd}), 160'({x.rs1, x.rs2, x.rd}));
          chk("ex_fields", 160'({ex_opcode, ex_funct3, ex_funct7b5}), 160'({x.opc, x.f3, x.f7}));
          chk("ex_ctl", 160'({ex_mem_read, ex_mem_write, ex_reg_write}), 160'({x.mr, x.mw, x.rw}));
        end
      end else begin
        chk("bubble_ctl", 160'({ex_mem_read, ex_mem_write, ex_reg_write}), 160'(0));
      end
    end
  end

  initial begin
    int e;
    int e2;
    n_chk    = 0;
    n_fail   = 0;
    edge_cnt = 0;
    rst_n    = 1'b0;
    if_valid = 1'b0;
    if_instr = 32'h0;
    if_pc    = 32'h0;
    flush_i  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ex_all", ex_all(), 160'(0));
    chk("reset_id_ready", 160'(id_ready), 160'(1));
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 32'h0, 32'h0, 0, 1, e);
    drive(0, 32'h0, 32'h0, 0, 1, e);
    chk("idle_ex_all", ex_all(), 160'(0));
    chk("idle_rf_addr", 160'({rf_a1, rf_a2}), 160'(0));

    // Independent instructions, one per cycle.
    drive(1, 32'h0050_0093, 32'h100, 0, 1, e);            // addi x1,x0,5
    push_exp(e + 2, 32'h100, 32'h0050_0093, 32'h5, 1, 0, 0, 0, 1);
    drive(1, 32'hFE20_8CE3, 32'h104, 0, 1, e);            // beq x1,x2,-8
    push_exp(e + 2, 32'h104, 32'hFE20_8CE3, 32'hFFFF_FFF8, 1, 1, 0, 0, 0);
    drive(1, 32'h0010_00EF, 32'h108, 0, 1, e);            // jal x1,+2048
    push_exp(e + 2, 32'h108, 32'h0010_00EF, 32'h0000_0800, 0, 0, 0, 0, 1);
    drive(1, 32'hFE20_AE23, 32'h10C, 0, 1, e);            // sw x2,-4(x1)
    push_exp(e + 2, 32'h10C, 32'hFE20_AE23, 32'hFFFF_FFFC, 1, 1, 0, 1, 0);
    drive(1, 32'hABCD_E2B7, 32'h110, 0, 1, e);            // lui x5,0xABCDE
    push_exp(e + 2, 32'h110, 32'hABCD_E2B7, 32'hABCD_E000, 0, 0, 0, 0, 1);
    drive(1, 32'hFFFF_FFFF, 32'h114, 0, 1, e);            // unknown opcode
    push_exp(e + 2, 32'h114, 32'hFFFF_FFFF, 32'h0, 0, 0, 0, 0, 0);

    // Load-use: lw x2,0(x1) then add x3,x2,x2 -> one stall, one bubble.
    drive(1, 32'h0000_A103, 32'h118, 0, 1, e);
    push_exp(e + 2, 32'h118, 32'h0000_A103, 32'h0, 1, 0, 1, 0, 1);
    drive(1, 32'h0021_01B3, 32'h11C, 0, 1, e2);
    push_exp(e2 + 3, 32'h11C, 32'h0021_01B3, 32'h0, 1, 1, 0, 0, 1);
    drive(1, 32'h0021_01B3, 32'h11C, 0, 0, e);
    drive(0, 32'h0, 32'h0, 0, 1, e);

    // lw x0 then add x3,x0,x0 -> no stall, lw does not write.
    drive(1, 32'h0000_A003, 32'h120, 0, 1, e);
    push_exp(e + 2, 32'h120, 32'h0000_A003, 32'h0, 1, 0, 1, 0, 0);
    drive(1, 32'h0000_01B3, 32'h124, 0, 1, e2);
    push_exp(e2 + 2, 32'h124, 32'h0000_01B3, 32'h0, 1, 1, 0, 0, 1);
    drive(0, 32'h0, 32'h0, 0, 1, e);

    // Flush during a stall: flush wins, stalled add and offered addi are lost.
    drive(1, 32'h0000_A103, 32'h128, 0, 1, e);
    push_exp(e + 2, 32'h128, 32'h0000_A103, 32'h0, 1, 0, 1, 0, 1);
    drive(1, 32'h0021_01B3, 32'h12C, 0, 1, e);
    drive(1, 32'h0050_0293, 32'h130, 1, 1, e);
    drive(0, 32'h0, 32'h0, 0, 1, e);
    chk("flush_ex_valid", 160'(ex_valid), 160'(0));
    chk("flush_rf_addr", 160'({rf_a1, rf_a2}), 160'(0));
    drive(0, 32'h0, 32'h0, 0, 1, e);
    drive(0, 32'h0, 32'h0, 0, 1, e);
`ifdef ID_STALL_CNT_EN
    chk("stall_cnt", 160'(stall_cnt), 160'(1));
    chk("flush_cnt", 160'(flush_cnt), 160'(1));
`endif

    // Reset asserted in the middle of a stall clears everything at once.
    drive(1, 32'h0000_A103, 32'h140, 0, 1, e);
    push_exp(e + 2, 32'h140, 32'h0000_A103, 32'h0, 1, 0, 1, 0, 1);
    drive(1, 32'h0021_01B3, 32'h144, 0, 1, e);
    drive(1, 32'h0021_01B3, 32'h144, 0, 0, e);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_ex_all", ex_all(), 160'(0));
    chk("midreset_id_ready", 160'(id_ready), 160'(1));
    chk("midreset_rf_addr", 160'({rf_a1, rf_a2}), 160'(0));
    @(negedge clk);
    rst_n    = 1'b1;
    if_valid = 1'b0;
    repeat (4) drive(0, 32'h0, 32'h0, 0, 1, e);

    chk("queue_empty", 160'(q.size()), 160'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
